alu_slice_reg: RTL and testbench

- Registered WIDTH-bit ALU built from a ripple chain of one-bit slices.
- Each slice has a full adder, AND/XOR/OR gates and an 8:1 operation mux.
- Selects one of eight operations by a 3-bit opcode.
- Registers the result and carry/overflow status on the clock.
- Sits in the datapath execute stage, between the operand registers and writeback.

---
 rtl/alu_slice_reg.sv | 132 +++++++++++++
 tb/tb_alu_slice_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_slice_reg.sv
// alu_slice_reg -- registered WIDTH-bit ALU for the execute stage.
//
// The datapath is a ripple chain of one-bit slices. Each slice holds a full
// adder, AND/OR/XOR gates and an 8:1 operation mux. The result and the
// carry/overflow status are registered, so latency is one cycle and a new
// operation is accepted every cycle.
//
// Parameters:
//   WIDTH      operand/result width in bits (minimum 2)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and opcode valid this cycle
//   a, b       operands
//   op         operation select:
//                000 b, 001 0, 010 a+b, 011 a-b,
//                100 a&b, 101 a|b, 110 a^b, 111 0
//   result     registered result
//   carry      registered carry out of the MSB (add/sub only; 1 = no borrow)
//   overflow   registered signed overflow (add/sub only)
//   out_valid  result/flags valid
//
// Optional build macro ALU_ZN_FLAGS_EN adds:
//   zero       registered result is all zeros
//   negative   registered result MSB

module alu_slice_reg #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
`ifdef ALU_ZN_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative
`endif
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_cin_msb;
  logic             w_arith;
  logic             w_c;
  logic             w_beff;
  logic             w_sum;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;
  logic             r_out_valid;

  assign w_arith = (op == 3'b010) || (op == 3'b011);

  // Slice chain, LSB first. w_c is the ripple carry between slices; the
  // value entering the last slice is kept as the carry into the MSB.
  always_comb begin
    w_res     = '0;
    w_c       = op[0];
    w_cin_msb = 1'b0;
    w_beff    = 1'b0;
    w_sum     = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_cin_msb = w_c;
      // Subtract shares the adder: invert B and inject carry-in on op[0].
      w_beff = b[IW'(i)] ^ op[0];
      w_sum  = a[IW'(i)] ^ w_beff ^ w_c;
      w_c    = (a[IW'(i)] & w_beff) | (w_c & (a[IW'(i)] ^ w_beff));
      // Logic ops always see the true B, not the adder's inverted copy.
      unique case (op)
        3'b000:  w_res[IW'(i)] = b[IW'(i)];
        3'b010,
        3'b011:  w_res[IW'(i)] = w_sum;
        3'b100:  w_res[IW'(i)] = a[IW'(i)] & b[IW'(i)];
        3'b101:  w_res[IW'(i)] = a[IW'(i)] | b[IW'(i)];
        3'b110:  w_res[IW'(i)] = a[IW'(i)] ^ b[IW'(i)];
        default: w_res[IW'(i)] = 1'b0;
      endcase
    end
    w_cout = w_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_result   <= w_res;
        r_carry    <= w_arith & w_cout;
        r_overflow <= w_arith & (w_cout ^ w_cin_msb);
      end
    end
  end

  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;

`ifdef ALU_ZN_FLAGS_EN
  logic r_zero;
  logic r_negative;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else if (in_valid) begin
      r_zero     <= (w_res == '0);
      r_negative <= w_res[WIDTH-1];
    end
  end

  assign zero     = r_zero;
  assign negative = r_negative;
`endif

endmodule

// File: tb/tb_alu_slice_reg.sv
// Self-checking bench for alu_slice_reg (WIDTH = 64).
// A wide-arithmetic reference model predicts every registered output; a
// compare process checks it each falling edge, and directed vectors pin
// literal expectations.

module tb_alu_slice_reg;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         out_valid;
`ifdef ALU_ZN_FLAGS_EN
  logic         zero;
  logic         negative;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  alu_slice_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .out_valid (out_valid)
`ifdef ALU_ZN_FLAGS_EN
    ,
    .zero      (zero),
    .negative  (negative)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } model_t;

  function automatic model_t model(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    model_t  m;
    logic [W:0] s;
    m = '0;
    case (o)
      3'd0: m.res = y;
      3'd2: begin
        s     = {1'b0, x} + {1'b0, y};
        m.res = s[W-1:0];
        m.c   = s[W];
        m.v   = (x[W-1] == y[W-1]) && (m.res[W-1] != x[W-1]);
      end
      3'd3: begin
        s     = {1'b0, x} + {1'b0, ~y} + 1;
        m.res = s[W-1:0];
        m.c   = (x >= y);
        m.v   = (x[W-1] != y[W-1]) && (m.res[W-1] != x[W-1]);
      end
      3'd4: m.res = x & y;
      3'd5: m.res = x | y;
      3'd6: m.res = x ^ y;
      default: m.res = '0;
    endcase
    return m;
  endfunction

  model_t exp_m;
  logic   exp_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_m     <= '0;
      exp_valid <= 1'b0;
    end else begin
      exp_valid <= in_valid;
      if (in_valid) exp_m <= model(op, a, b);
    end
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    check("m_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    check("m_result", result, exp_m.res);
    check("m_carry", {63'd0, carry}, {63'd0, exp_m.c});
    check("m_overflow", {63'd0, overflow}, {63'd0, exp_m.v});
`ifdef ALU_ZN_FLAGS_EN
    check("m_zero", {63'd0, zero}, {63'd0, (exp_m.res == '0)});
    check("m_negative", {63'd0, negative}, {63'd0, exp_m.res[W-1]});
`endif
  end

  // Directed vector: drive one op, idle afterwards, check literals.
  task automatic run(input string name, input logic [2:0] o,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] r, input logic c, input logic v);
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "_res"}, result, r);
    check({name, "_c"}, {63'd0, carry}, {63'd0, c});
    check({name, "_v"}, {63'd0, overflow}, {63'd0, v});
    check({name, "_ov"}, {63'd0, out_valid}, 64'd1);
`ifdef ALU_ZN_FLAGS_EN
    check({name, "_z"}, {63'd0, zero}, {63'd0, (r == '0)});
    check({name, "_n"}, {63'd0, negative}, {63'd0, r[W-1]});
`endif
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_res"}, result, '0);
    check({name, "_c"}, {63'd0, carry}, 64'd0);
    check({name, "_v"}, {63'd0, overflow}, 64'd0);
    check({name, "_ov"}, {63'd0, out_valid}, 64'd0);
  endtask

  localparam logic [W-1:0] SA = 64'd62583;
  localparam logic [W-1:0] SB = 64'd69384;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;
    #12;
    check_zero_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Asynchronous reset mid-stream, between clock edges.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'b010; a = 64'd7; b = 64'd8;
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'b011; a = 64'd1; b = 64'd2;
    check("pre_rst_res", result, 64'd15);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero_outputs("post_rst_idle");

    // Logic sweep.
    run("op000", 3'b000, SA, SB, 64'd69384, 1'b0, 1'b0);
    run("op001", 3'b001, SA, SB, 64'd0, 1'b0, 1'b0);
    run("op010", 3'b010, SA, SB, 64'd131967, 1'b0, 1'b0);
    run("op011", 3'b011, SA, SB, 64'hFFFF_FFFF_FFFF_E56F, 1'b0, 1'b0);
    run("op100", 3'b100, SA, SB, 64'd1024, 1'b0, 1'b0);
    run("op101", 3'b101, SA, SB, 64'h1FF7F, 1'b0, 1'b0);
    run("op110", 3'b110, SA, SB, 64'h1FB7F, 1'b0, 1'b0);
    run("op111", 3'b111, SA, SB, 64'd0, 1'b0, 1'b0);

    // Add / subtract boundaries.
    run("add_ovf", 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
        64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run("add_wrap", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0);
    run("sub_eq", 3'b011, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0);
    run("sub_ovf", 3'b011, 64'h8000_0000_0000_0000, 64'd1,
        64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run("neg_add", 3'b010, -64'd12381, -64'd85943, -64'd98324, 1'b1, 1'b0);
    run("neg_sub", 3'b011, -64'd12381, -64'd85943, 64'd73562, 1'b1, 1'b0);

    // Back-to-back stream, one op per cycle, checked by the model.
    for (int unsigned k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      op = 3'(k);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
    end

    // Valid pulse then hold while inputs wander.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 3'b010; a = 64'd1; b = 64'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 64'd100; b = 64'd200;
    @(negedge clk);
    check("hold_first_res", result, 64'd3);
    check("hold_first_ov", {63'd0, out_valid}, 64'd1);
    for (int unsigned k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      a = 64'(k + 1000); b = 64'(k * 7); op = 3'(k);
      @(negedge clk);
      check("hold_res", result, 64'd3);
      check("hold_ov", {63'd0, out_valid}, 64'd0);
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
